// File: rtl/conv_stream_bist.sv
// conv_stream_bist: built-in self-test engine for the convolution filter
// datapath. Loads a coefficient mask into the filter, streams pseudo-random
// frames with frame sync, folds the filter output into a MISR signature and
// compares it against a golden value.
//
// Ports:
//   clk, reset                  clock / asynchronous active-high reset
//   io_start                    run request, honoured in IDLE or DONE
//   io_image_width/height       frame width-1 / height-1
//   io_num_images               frames per run (0 treated as 1)
//   io_seed                     LFSR seed (0 replaced by 16'hACE1)
//   io_coeff_idx / io_coeff_in  mask index requested / host coefficient
//   io_expected_sig             golden signature
//   io_dut_config_load/coeff    filter mask load
//   io_dut_frame_sync_in/data_in   filter input stream
//   io_dut_frame_sync_out/data_out filter output stream
//   io_busy, io_done, io_pass, io_sync_err, io_timeout   status
//   io_signature                current MISR value
//
// Optional feature: define CONV_BIST_TIMEOUT_EN to abort the run when no
// frame_sync_out arrives within TIMEOUT_CYCLES of stream entry.
module conv_stream_bist #(
  parameter int          PIXEL_W        = 8,
  parameter int          COEFF_W        = 16,
  parameter int          NUM_COEFFS     = 25,
  parameter int          DIM_W          = 10,
  parameter int          SIG_W          = 32,
  parameter logic [31:0] SIG_POLY       = 32'h04C11DB7,
  parameter int          TIMEOUT_CYCLES = 4096,
  localparam int         CIDX_W         = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_start,
  input  logic [DIM_W-1:0]   io_image_width,
  input  logic [DIM_W-1:0]   io_image_height,
  input  logic [7:0]         io_num_images,
  input  logic [15:0]        io_seed,
  output logic [CIDX_W-1:0]  io_coeff_idx,
  input  logic [COEFF_W-1:0] io_coeff_in,
  input  logic [SIG_W-1:0]   io_expected_sig,
  output logic               io_dut_config_load,
  output logic [COEFF_W-1:0] io_dut_coeff,
  output logic               io_dut_frame_sync_in,
  output logic [PIXEL_W-1:0] io_dut_data_in,
  input  logic               io_dut_frame_sync_out,
  input  logic [PIXEL_W-1:0] io_dut_data_out,
  output logic               io_busy,
  output logic               io_done,
  output logic               io_pass,
  output logic               io_sync_err,
  output logic               io_timeout,
  output logic [SIG_W-1:0]   io_signature
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_STREAM, S_DONE} state_t;

  localparam logic [CIDX_W-1:0] K_LAST = CIDX_W'(NUM_COEFFS - 1);

  state_t             state_q, state_d;
  logic [CIDX_W-1:0]  k_q;
  logic [DIM_W-1:0]   w_q, h_q;
  logic [7:0]         n_q;
  logic [SIG_W-1:0]   exp_q, sig_q, misr_nx;
  logic [15:0]        lfsr_q, lfsr_nx;
  logic               sync_err_q;
  // input-side position
  logic [DIM_W-1:0]   ix_q, iy_q;
  logic [7:0]         iimg_q;
  logic               in_run_q;
  // capture-side position
  logic [DIM_W-1:0]   cx_q, cy_q;
  logic [7:0]         cimg_q;
  logic               cap_on_q;

  logic start_ok, cap_now, cap_pix0, cap_last, timeout_hit;

  assign start_ok = io_start && (state_q == S_IDLE || state_q == S_DONE);
  // Capture begins on the first frame_sync_out after stream entry.
  assign cap_now  = (state_q == S_STREAM) && (cap_on_q || io_dut_frame_sync_out);
  assign cap_pix0 = (cx_q == '0) && (cy_q == '0);
  assign cap_last = cap_now && (cx_q == w_q) && (cy_q == h_q) && (cimg_q == n_q - 8'd1);

  assign lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign misr_nx = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? SIG_POLY[SIG_W-1:0] : '0)
                 ^ SIG_W'(io_dut_data_out);

`ifdef CONV_BIST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] tcnt_q;
  logic            timeout_q;

  assign timeout_hit = (state_q == S_STREAM) && !cap_on_q && !io_dut_frame_sync_out
                    && (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign io_timeout  = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == S_GAP) begin
      tcnt_q    <= '0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end else if (state_q == S_STREAM && !cap_on_q && !io_dut_frame_sync_out) begin
      tcnt_q    <= tcnt_q + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign io_timeout  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_LOAD;
      S_LOAD:         if (k_q == K_LAST) state_d = S_GAP;
      S_GAP:          state_d = S_STREAM;
      S_STREAM:       if (cap_last || timeout_hit) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= S_IDLE;
      k_q                  <= '0;
      w_q                  <= '0;
      h_q                  <= '0;
      n_q                  <= '0;
      exp_q                <= '0;
      lfsr_q               <= '0;
      sig_q                <= '1;
      sync_err_q           <= 1'b0;
      ix_q                 <= '0;
      iy_q                 <= '0;
      iimg_q               <= '0;
      in_run_q             <= 1'b0;
      cx_q                 <= '0;
      cy_q                 <= '0;
      cimg_q               <= '0;
      cap_on_q             <= 1'b0;
      io_dut_config_load   <= 1'b0;
      io_dut_coeff         <= '0;
      io_dut_frame_sync_in <= 1'b0;
      io_dut_data_in       <= '0;
    end else begin
      state_q              <= state_d;
      io_dut_config_load   <= 1'b0;
      io_dut_coeff         <= '0;
      io_dut_frame_sync_in <= 1'b0;
      io_dut_data_in       <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            w_q        <= io_image_width;
            h_q        <= io_image_height;
            n_q        <= (io_num_images == 8'd0) ? 8'd1 : io_num_images;
            lfsr_q     <= (io_seed == 16'd0) ? 16'hACE1 : io_seed;
            exp_q      <= io_expected_sig;
            sig_q      <= '1;
            sync_err_q <= 1'b0;
            k_q        <= '0;
          end
        end
        S_LOAD: begin
          io_dut_config_load <= 1'b1;
          io_dut_coeff       <= io_coeff_in;
          k_q                <= (k_q == K_LAST) ? '0 : k_q + CIDX_W'(1);
        end
        S_GAP: begin
          in_run_q <= 1'b1;
          ix_q     <= '0;
          iy_q     <= '0;
          iimg_q   <= '0;
          cx_q     <= '0;
          cy_q     <= '0;
          cimg_q   <= '0;
          cap_on_q <= 1'b0;
        end
        S_STREAM: begin
          if (in_run_q) begin
            io_dut_frame_sync_in <= (ix_q == '0) && (iy_q == '0);
            io_dut_data_in       <= lfsr_q[PIXEL_W-1:0];
            lfsr_q               <= lfsr_nx;
            if (ix_q == w_q) begin
              ix_q <= '0;
              if (iy_q == h_q) begin
                iy_q <= '0;
                if (iimg_q == n_q - 8'd1) in_run_q <= 1'b0;
                else                      iimg_q   <= iimg_q + 8'd1;
              end else begin
                iy_q <= iy_q + DIM_W'(1);
              end
            end else begin
              ix_q <= ix_q + DIM_W'(1);
            end
          end
          // Capture counters are zero before the first sync, so the opening
          // pulse is checked against pixel 0 like every later frame start.
          if (cap_now) begin
            sig_q    <= misr_nx;
            cap_on_q <= 1'b1;
            if (io_dut_frame_sync_out != cap_pix0) sync_err_q <= 1'b1;
            if (cx_q == w_q) begin
              cx_q <= '0;
              if (cy_q == h_q) begin
                cy_q   <= '0;
                cimg_q <= cimg_q + 8'd1;
              end else begin
                cy_q <= cy_q + DIM_W'(1);
              end
            end else begin
              cx_q <= cx_q + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_coeff_idx = k_q;
  assign io_busy      = (state_q == S_LOAD) || (state_q == S_GAP) || (state_q == S_STREAM);
  assign io_done      = (state_q == S_DONE);
  assign io_pass      = io_done && !sync_err_q && !io_timeout && (sig_q == exp_q);
  assign io_sync_err  = sync_err_q;
  assign io_signature = sig_q;

endmodule
